// File: rtl/fetch_ir.sv
// Instruction fetch / instruction-register stage: captures the ROM word at the current PC each edge.
// Optional macro FETCH_FLUSH_EN squashes the jump slot into a bubble instead of executing it as a delay slot.
module fetch_ir #(
    parameter bit          LOG = 1'b0,
    parameter logic [47:0] NOP = 48'h0
) (
    input  logic        clk_i,
    input  logic        _MR_i,
    input  logic [7:0]  PCHI_i,
    input  logic [7:0]  PCLO_i,
    input  logic [47:0] rom_data_i,
    input  logic        _jump_taken_i,
    input  logic        _halt_i,
    output logic [15:0] rom_addr_o,
    output logic [47:0] IR_o,
    output logic [15:0] IR_PC_o,
    output logic        ir_valid_o,
    output logic        halted_o,
    output logic [15:0] fetch_count_o
);

    typedef enum logic [1:0] {
        RESET  = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [47:0] ir_q, ir_d;
    logic [15:0] irPc_q, irPc_d;
    logic        irValid_q, irValid_d;
    logic        halted_q, halted_d;
    logic [15:0] fetchCount_q, fetchCount_d;
    logic        flush;

    assign rom_addr_o = {PCHI_i, PCLO_i};

`ifdef FETCH_FLUSH_EN
    assign flush = ~_jump_taken_i;
`else
    // Without flushing the jump slot simply executes, so the jump strobe has no effect here.
    logic unused_jump_taken;
    assign unused_jump_taken = _jump_taken_i;
    assign flush = 1'b0;
`endif

    // Per-edge trace is produced by the surrounding environment; LOG only selects it.
    if (LOG) begin : g_log
    end

    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        irPc_d       = irPc_q;
        irValid_d    = irValid_q;
        halted_d     = halted_q;
        fetchCount_d = fetchCount_q;
        if (state_q != HALTED) begin
            if (!_halt_i) begin
                state_d   = HALTED;
                ir_d      = NOP;
                irValid_d = 1'b0;
                halted_d  = 1'b1;
            end else if (flush) begin
                state_d   = BUBBLE;
                ir_d      = NOP;
                irPc_d    = rom_addr_o;
                irValid_d = 1'b0;
            end else begin
                state_d      = RUN;
                ir_d         = rom_data_i;
                irPc_d       = rom_addr_o;
                irValid_d    = 1'b1;
                fetchCount_d = fetchCount_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge _MR_i) begin
        if (!_MR_i) begin
            state_q      <= RESET;
            ir_q         <= NOP;
            irPc_q       <= 16'h0000;
            irValid_q    <= 1'b0;
            halted_q     <= 1'b0;
            fetchCount_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            irPc_q       <= irPc_d;
            irValid_q    <= irValid_d;
            halted_q     <= halted_d;
            fetchCount_q <= fetchCount_d;
        end
    end

    assign IR_o          = ir_q;
    assign IR_PC_o       = irPc_q;
    assign ir_valid_o    = irValid_q;
    assign halted_o      = halted_q;
    assign fetch_count_o = fetchCount_q;

endmodule

// File: doc/fetch_ir.md
# fetch_ir

Instruction fetch and instruction-register stage directly downstream of the program counter. Presents the PC value as the program-ROM address, captures the 48-bit ROM word into the instruction register on each rising clock, and tags it with the address it came from. Handles the branch slot after a taken jump, a sticky halt, and keeps a retired-fetch counter for debug.

## Interface
- LOG, 0, when 1 print a line per clock edge with state, IR, IR_PC, count
- NOP, 48'h0, bubble word loaded into IR on reset, flush and halt

- clk  in  1  system clock; all state advances on rising edge
- _MR  in  1  reset, asynchronous, active-low; overrides everything
- PCHI  in  8  PC high byte from the PC stage
- PCLO  in  8  PC low byte from the PC stage
- rom_data  in  48  program ROM output for rom_addr (combinational ROM)
- _jump_taken  in  1  active-low; low during an edge means the PC is loading a jump target at that edge
- _halt  in  1  active-low halt request, sampled on rising edge
- rom_addr  out  16  {PCHI, PCLO}, combinational pass-through
- IR  out  48  instruction register
- IR_PC  out  16  address IR was fetched from
- ir_valid  out  1  high when IR holds a real fetched instruction
- halted  out  1  high in HALTED state
- fetch_count  out  16  count of valid instructions loaded

## Operation
- States: RESET, RUN, BUBBLE, HALTED; state register 2 bits.
- _MR low (async, any time): state=RESET, IR=NOP, IR_PC=0, ir_valid=0, halted=0, fetch_count=0. rom_addr keeps tracking PC.
- Priority at each rising edge (when _MR high): halt > flush > load.
- _halt low at edge (from RESET, RUN or BUBBLE): IR=NOP, ir_valid=0, state=HALTED, halted=1. HALTED is sticky: ignores _halt, _jump_taken, rom_data; exits only via _MR.
- Flush (FETCH_FLUSH_EN defined, _jump_taken low, _halt high): IR=NOP, IR_PC=rom_addr, ir_valid=0, state=BUBBLE, fetch_count unchanged.
- Load otherwise: IR=rom_data, IR_PC=rom_addr, ir_valid=1, state=RUN, fetch_count=fetch_count+1.
- BUBBLE lasts exactly one cycle unless another flush or halt is taken; back-to-back jumps give back-to-back bubbles.
- RESET->RUN on first edge after _MR release (unless halt/flush applies).
- fetch_count is 16-bit modulo: FFFF+1 -> 0000, no saturation or flag.
- IR_PC captures full 16 bits; FFFF wraps naturally via the PC, no special case here.

## Timing
- Zero-latency address: rom_addr = {PCHI,PCLO} combinationally.
- One-cycle fetch latency: edge k captures ROM[PC_k]; PC stage moves to PC_k+1 on the same edge.
- Jump slot: jump at address A sits in IR during cycle after fetch; decoder drives _jump_taken low; at that edge PC loads target T and ROM[A+1] is presented. Flush discards it; without flush it executes as a delay slot.
- Instruction at T appears in IR one edge after the jump edge.
- _jump_taken, _halt must be stable setup-before rising edge; no async effect.
- _MR deassertion must meet recovery time to clk; asserting mid-cycle clears outputs immediately.

## Configuration
- FETCH_FLUSH_EN defined: taken jump squashes the slot word (BUBBLE, ir_valid=0, count not incremented).
- FETCH_FLUSH_EN undefined: _jump_taken ignored; BUBBLE state unreachable; slot instruction at A+1 loaded and counted as a normal fetch (branch delay slot semantics).

## Test plan
- Reset: _MR low with rom_data=48'hABCDEF123456 -> IR=NOP, IR_PC=0000, ir_valid=0, fetch_count=0, halted=0 immediately without a clock.
- Sequential fetch: PC 0000..0003 with rom_data=address-tagged words -> IR_PC lags PC by one edge, ir_valid=1, fetch_count=4 after 4 edges.
- Jump flush (macro on): jump at 0010 to 0200 -> IR_PC=0011 with IR=NOP, ir_valid=0, then IR_PC=0200 valid; count +1 only for 0200; macro off: IR_PC=0011 valid with ROM[0011], count +1.
- Back-to-back jumps (macro on): _jump_taken low two consecutive edges -> two BUBBLE cycles, count unchanged.
- Halt: _halt low one edge during RUN -> HALTED, IR=NOP, halted=1; later _halt high and rom changes -> outputs frozen; _MR pulse -> RESET values.
- Counter wrap: preload by running 65536 valid fetches -> fetch_count returns to 0000, no other state change; _MR asserted mid-cycle during RUN -> count 0 at once.
